// File: rtl/snpu_entropy_pool.sv
// snpu_entropy_pool: harvests words from a bank of free-running RNG sources.
// The raw bus is synchronised, sampled, condensed by one of four modes (raw
// select, XOR fold, von Neumann debias, LFSR-whitened fold) and queued in a
// first-word-fall-through FIFO behind a valid/ready port.
module snpu_entropy_pool #(
    parameter int               N_SRC      = 32,
    parameter int               W_SRC      = 16,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [W_SRC-1:0] LFSR_TAPS  = 16'hB400,
    parameter logic [W_SRC-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_SRC*W_SRC-1:0]           src_bus,
    input  logic                             freeze,
    input  logic [1:0]                       mode,
    input  logic [$clog2(N_SRC)-1:0]         addr,
    input  logic                             clr_ovf,
    output logic [W_SRC-1:0]                 out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             overflow
);

    localparam int AW = $clog2(N_SRC);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(W_SRC);
    localparam int BW = N_SRC * W_SRC;

    typedef enum logic [1:0] {
        MODE_RAW   = 2'd0,
        MODE_FOLD  = 2'd1,
        MODE_VN    = 2'd2,
        MODE_WHITE = 2'd3
    } mode_e;

    // Synchroniser and sample stage
    logic [BW-1:0]    sync1_q, sync1_d;
    logic [BW-1:0]    sync2_q, sync2_d;
    logic [BW-1:0]    s_q, s_d;

    // Conditioning state
    logic [W_SRC-1:0] lfsr_q, lfsr_d;
    logic [W_SRC-1:0] vn_acc_q, vn_acc_d;
    logic [CW-1:0]    vn_cnt_q, vn_cnt_d;
    logic [1:0]       mode_prev_q, mode_prev_d;

    // FIFO state
    logic [W_SRC-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;

    // Combinational word path
    mode_e            mode_w;
    logic [W_SRC-1:0] sel_w;
    logic [W_SRC-1:0] fold_w;
    logic [W_SRC-1:0] word_w;
    logic             push_w;
    logic             mode_chg_w;
    logic             full_w;
    logic             empty_w;
    logic             pop_w;
    logic             wr_en_w;
    logic             drop_w;

    assign mode_w     = mode_e'(mode);
    assign mode_chg_w = (mode != mode_prev_q);
    assign full_w     = (level_q == LW'(FIFO_DEPTH));
    assign empty_w    = (level_q == '0);

    // Select the addressed source word and XOR-fold all sources from the sample reg
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        sel_w  = '0;
        fold_w = '0;
        for (int i = 0; i < N_SRC; i++) begin
            fold_w = fold_w ^ s_q[i*W_SRC +: W_SRC];
            if (addr == AW'(i)) begin
                sel_w = s_q[i*W_SRC +: W_SRC];
            end
        end
    end

    // Next-state for sampling, conditioning modes and the word candidate
    always_comb begin
        sync1_d     = src_bus;
        sync2_d     = sync1_q;
        s_d         = freeze ? s_q : sync2_q;
        lfsr_d      = lfsr_q;
        vn_acc_d    = vn_acc_q;
        vn_cnt_d    = vn_cnt_q;
        mode_prev_d = mode;
        push_w      = 1'b0;
        word_w      = '0;

        if (!freeze) begin
            if (mode_chg_w) begin
                // A mode switch discards any partial VN word and emits nothing.
                vn_cnt_d = '0;
            end else begin
                unique case (mode_w)
                    MODE_RAW: begin
                        push_w = 1'b1;
                        word_w = sel_w;
                    end
                    MODE_FOLD: begin
                        push_w = 1'b1;
                        word_w = fold_w;
                    end
                    MODE_VN: begin
                        // Unequal pair yields its low bit; equal pairs are biased and dropped.
                        if (sel_w[1] != sel_w[0]) begin
                            vn_acc_d = {vn_acc_q[W_SRC-2:0], sel_w[0]};
                            if (vn_cnt_q == CW'(W_SRC - 1)) begin
                                push_w   = 1'b1;
                                word_w   = vn_acc_d;
                                vn_cnt_d = '0;
                            end else begin
                                vn_cnt_d = vn_cnt_q + 1'b1;
                            end
                        end
                    end
                    MODE_WHITE: begin
                        push_w = 1'b1;
                        word_w = fold_w ^ lfsr_q;
                        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
                    end
                    default: begin
                        push_w = 1'b0;
                    end
                endcase
            end
        end
    end

    // FIFO control: pop, push-through at full, drop-and-flag at full without pop
    always_comb begin
        pop_w      = out_ready && !empty_w;
        wr_en_w    = push_w && (!full_w || pop_w) && !rst;
        drop_w     = push_w && full_w && !pop_w;
        wr_ptr_d   = wr_en_w ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop_w ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d    = level_q + LW'(wr_en_w) - LW'(pop_w);
        overflow_d = drop_w ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            s_q         <= '0;
            lfsr_q      <= LFSR_SEED;
            vn_acc_q    <= '0;
            vn_cnt_q    <= '0;
            mode_prev_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            s_q         <= s_d;
            lfsr_q      <= lfsr_d;
            vn_acc_q    <= vn_acc_d;
            vn_cnt_q    <= vn_cnt_d;
            mode_prev_q <= mode_prev_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; the empty flag masks stale entries.
        if (wr_en_w) begin
            fifo_mem_q[wr_ptr_q] <= word_w;
        end
    end

    assign out_valid  = !empty_w;
    assign out_data   = empty_w ? '0 : fifo_mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_snpu_entropy_pool.sv
// Testbench for snpu_entropy_pool: directed vectors, expected words queued at
// stimulus time and compared by an independent monitor on each handshake.
module tb_snpu_entropy_pool;

    localparam int N_SRC = 32;
    localparam int W_SRC = 16;
    localparam int FIFO_DEPTH = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [N_SRC*W_SRC-1:0]     src_bus;
    logic                       freeze;
    logic [1:0]                 mode;
    logic [4:0]                 addr;
    logic                       clr_ovf;
    logic [W_SRC-1:0]           out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [2:0]                 fifo_level;
    logic                       overflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit sb_en   = 1'b0;
    logic [W_SRC-1:0] exp_q [$];

    snpu_entropy_pool #(
        .N_SRC(N_SRC), .W_SRC(W_SRC), .FIFO_DEPTH(FIFO_DEPTH),
        .LFSR_TAPS(16'hB400), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .src_bus(src_bus), .freeze(freeze), .mode(mode),
        .addr(addr), .clr_ovf(clr_ovf), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_src(input int idx, input logic [W_SRC-1:0] val);
        src_bus[idx*W_SRC +: W_SRC] = val;
    endtask

    // Enter mode m from a frozen state: one frozen cycle in another mode, then an
    // unfrozen mode-change cycle that loads the sample reg without pushing.
    task automatic prime(input logic [1:0] m);
        mode = m ^ 2'd1;
        cyc();
        freeze = 1'b0;
        mode   = m;
        cyc();
    endtask

    task automatic expect_word(input logic [W_SRC-1:0] w);
        exp_q.push_back(w);
        cyc();
    endtask

    task automatic drain_check(input string name);
        freeze = 1'b1;
        cyc(4);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_fifo_empty"}, {31'd0, out_valid}, 0);
    endtask

    // Monitor: every accepted word is compared with the oldest expected word
    always @(negedge clk) begin
        if (sb_en && !rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", {16'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check("sb_word", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1; freeze = 1'b1; mode = 2'd0; addr = 5'd0; clr_ovf = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N_SRC; i++) set_src(i, 16'hDEAD);

        // T1 reset
        cyc(2);
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_level", {29'd0, fifo_level}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_data", {16'd0, out_data}, 0);
        rst = 1'b0;
        src_bus = '0;

        // T2 raw latency
        freeze = 1'b0; mode = 2'd0; addr = 5'd3; out_ready = 1'b1;
        cyc(4);
        set_src(3, 16'h1234);
        cyc(3);
        check("lat_c3_valid", {31'd0, out_valid}, 1);
        check("lat_c3_data", {16'd0, out_data}, 0);
        cyc();
        check("lat_c4_data", {16'd0, out_data}, 32'h1234);
        cyc();
        check("lat_c5_data", {16'd0, out_data}, 32'h1234);
        check("lat_c5_level", {29'd0, fifo_level}, 1);
        freeze = 1'b1;
        cyc(2);
        check("lat_empty_valid", {31'd0, out_valid}, 0);
        check("lat_empty_data", {16'd0, out_data}, 0);

        // T3 xor fold
        sb_en = 1'b1;
        for (int i = 0; i < N_SRC; i++) set_src(i, 16'(i));
        cyc(3);
        prime(2'd1);
        for (int k = 0; k < 3; k++) expect_word(16'h0000);
        drain_check("fold0");
        set_src(0, 16'h00FF);
        cyc(3);
        prime(2'd1);
        for (int k = 0; k < 3; k++) expect_word(16'h00FF);
        drain_check("fold1");

        // T4 von Neumann
        addr = 5'd0;
        set_src(0, 16'h0003);
        cyc(3);
        prime(2'd2);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hFFFF);
        for (int k = 0; k < 32; k++) begin set_src(0, (k % 2 == 0) ? 16'h0002 : 16'h0003); cyc(); end
        set_src(0, 16'h0003);
        cyc(8);
        for (int k = 0; k < 32; k++) begin set_src(0, (k % 2 == 0) ? 16'h0001 : 16'h0003); cyc(); end
        set_src(0, 16'h0003);
        cyc(10);
        drain_check("vn");

        // T5 overflow
        sb_en = 1'b0; out_ready = 1'b0; addr = 5'd5;
        set_src(5, 16'h1005);
        cyc(3);
        prime(2'd0);
        cyc(4);
        check("ovf_full_level", {29'd0, fifo_level}, FIFO_DEPTH);
        check("ovf_full_flag", {31'd0, overflow}, 0);
        check("ovf_full_head", {16'd0, out_data}, 32'h1005);
        cyc();
        check("ovf_set_flag", {31'd0, overflow}, 1);
        check("ovf_set_level", {29'd0, fifo_level}, FIFO_DEPTH);
        freeze = 1'b1;
        set_src(5, 16'hBEEF);
        cyc(3);
        freeze = 1'b0;
        cyc(2);
        check("ovf_drop_head", {16'd0, out_data}, 32'h1005);
        check("ovf_drop_level", {29'd0, fifo_level}, FIFO_DEPTH);
        out_ready = 1'b1;
        cyc();
        check("ovf_pushpop_level", {29'd0, fifo_level}, FIFO_DEPTH);
        check("ovf_pushpop_flag", {31'd0, overflow}, 1);
        out_ready = 1'b0; clr_ovf = 1'b1;
        cyc();
        check("ovf_set_wins", {31'd0, overflow}, 1);
        freeze = 1'b1;
        cyc();
        check("ovf_cleared", {31'd0, overflow}, 0);
        clr_ovf = 1'b0; out_ready = 1'b1;
        check("ovf_pop0", {16'd0, out_data}, 32'h1005); cyc();
        check("ovf_pop1", {16'd0, out_data}, 32'h1005); cyc();
        check("ovf_pop2", {16'd0, out_data}, 32'h1005); cyc();
        check("ovf_pop3", {16'd0, out_data}, 32'hBEEF); cyc();
        check("ovf_empty", {31'd0, out_valid}, 0);

        // T6 whitening with freeze
        sb_en = 1'b1;
        src_bus = '0;
        cyc(3);
        prime(2'd3);
        expect_word(16'hACE1);
        expect_word(16'hE270);
        expect_word(16'h7138);
        freeze = 1'b1;
        cyc(3);
        check("frz_queue_empty", exp_q.size(), 0);
        check("frz_no_push", {31'd0, out_valid}, 0);
        freeze = 1'b0;
        expect_word(16'h389C);
        expect_word(16'h1C4E);
        expect_word(16'h0E27);
        drain_check("white");

        // T7 reset mid-operation restarts the FIFO and the LFSR
        sb_en = 1'b0; out_ready = 1'b0; freeze = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc();
        rst = 1'b0; freeze = 1'b1;
        check("mid_rst_level", {29'd0, fifo_level}, 0);
        check("mid_rst_valid", {31'd0, out_valid}, 0);
        sb_en = 1'b1; out_ready = 1'b1;
        cyc(3);
        prime(2'd3);
        expect_word(16'hACE1);
        expect_word(16'hE270);
        drain_check("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
